// File: rtl/sim_uart_pkg.sv
// Shared types and width helpers for the simulation UART sink.
package sim_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;

  function automatic int cnt_w(input int clks);
    return (clks > 2) ? $clog2(clks) : 1;
  endfunction

  // One extra pointer bit separates full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sim_uart_fifo.sv
// Byte FIFO for the UART sink; head reads as zero while empty.
module sim_uart_fifo
  import sim_uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  always_comb begin
    empty = (wr_q == rd_q);
    full  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    rd_en = pop && !empty;
    // A pop frees the head slot on the same edge, so a full FIFO still accepts.
    wr_en = push && (!full || rd_en);
    wr_d  = wr_en ? wr_q + PW'(1) : wr_q;
    rd_d  = rd_en ? rd_q + PW'(1) : rd_q;
    head  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sim_uart_sink.sv
// Simulation UART receiver: synchroniser, 8N1 deserialiser, byte FIFO, flags.
// Optional console echo when SIM_UART_PRINT_EN is defined.
module sim_uart_sink
  import sim_uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] HALT_BYTE    = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        framing_err,
  output logic        overflow,
  output logic        halt,
  output logic [31:0] byte_cnt
);

  localparam int                CNT_W    = cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]        BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic                      rx_m_q, rx_s_q;
  rx_state_t                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      framing_err_q, framing_err_d;
  logic                      overflow_q, overflow_d;
  logic                      halt_q, halt_d;
  logic [31:0]               byte_cnt_q, byte_cnt_d;
  logic                      stop_ok, push, pop, push_acc;
  logic                      fifo_full, fifo_empty;

  // Stage 0: two-flop synchroniser, idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= rx_i;
      rx_s_q <= rx_m_q;
    end
  end

  // Stage 1: deserialiser next-state and flag logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shreg_d       = shreg_q;
    framing_err_d = 1'b0;
    stop_ok       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shreg_d[bit_q] = rx_s_q;
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) stop_ok       = 1'b1;
          else        framing_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    pop        = !fifo_empty && out_ready;
    push       = stop_ok && (shreg_q != HALT_BYTE);
    push_acc   = push && (!fifo_full || pop);
    halt_d     = halt_q | (stop_ok && (shreg_q == HALT_BYTE));
    overflow_d = overflow_q | (push && fifo_full && !pop);
    byte_cnt_d = byte_cnt_q + {31'd0, push_acc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
      halt_q        <= 1'b0;
      byte_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      framing_err_q <= framing_err_d;
      overflow_q    <= overflow_d;
      halt_q        <= halt_d;
      byte_cnt_q    <= byte_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  // Stage 2: byte FIFO towards the consumer.
  sim_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg_q),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (out_data)
  );

  assign out_valid   = !fifo_empty;
  assign framing_err = framing_err_q;
  assign overflow    = overflow_q;
  assign halt        = halt_q;
  assign byte_cnt    = byte_cnt_q;

`ifdef SIM_UART_PRINT_EN
  always @(posedge clk) begin
    if (!rst) begin
      if (push_acc) $write("%c", shreg_q);
      if (halt_d && !halt_q) $display("[halt] %0d bytes", byte_cnt_q);
    end
  end
`endif

endmodule

// File: tb/tb_sim_uart_sink.sv
// Directed plus randomized bench for sim_uart_sink with a frame-level reference model.
module tb_sim_uart_sink;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_i = 1'b1;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        framing_err;
  logic        overflow;
  logic        halt;
  logic [31:0] byte_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what the consumer should see, at frame level.
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         m_occ, m_cnt;
  logic       m_ovf, m_halt;
  int         valid_cycles, fe_cycles;

  sim_uart_sink #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .HALT_BYTE(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_i),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .framing_err (framing_err),
    .overflow    (overflow),
    .halt        (halt),
    .byte_cnt    (byte_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (framing_err) fe_cycles++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop) return;
    if (b == 8'h00) begin
      m_halt = 1'b1;
    end else if (!out_ready && m_occ >= DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      exp_q.push_back(b);
      m_cnt++;
      if (!out_ready) m_occ++;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk) rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = stop;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (4) @(negedge clk);
    model_frame(b, stop);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    rx_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ferr", {31'd0, framing_err}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_cnt", byte_cnt, 32'd0);
    exp_q.delete();
    got_q.delete();
    m_occ = 0; m_cnt = 0; m_ovf = 1'b0; m_halt = 1'b0;
    valid_cycles = 0; fe_cycles = 0;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    check({tag, "_cnt"}, byte_cnt, 32'(m_cnt));
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
    check({tag, "_halt"}, {31'd0, halt}, {31'd0, m_halt});
  endtask

  initial begin
    logic [7:0] rb;
    do_reset();

    // Single byte, consumer always ready.
    send_frame(8'h41, 1'b1);
    repeat (4) @(negedge clk);
    compare_stream("t1");
    check("t1_valid_cycles", 32'(valid_cycles), 32'd1);
    check("t1_ferr", 32'(fe_cycles), 32'd0);

    // Short low glitch is rejected.
    do_reset();
    @(negedge clk) rx_i = 1'b0;
    repeat (5) @(negedge clk);
    rx_i = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("t2_valid_cycles", 32'(valid_cycles), 32'd0);
    check("t2_ferr", 32'(fe_cycles), 32'd0);
    check("t2_cnt", byte_cnt, 32'd0);

    // Bad stop bit.
    send_frame(8'h55, 1'b0);
    repeat (CPB) @(negedge clk);
    check("t3_ferr_cycles", 32'(fe_cycles), 32'd1);
    check("t3_valid_cycles", 32'(valid_cycles), 32'd0);
    check("t3_cnt", byte_cnt, 32'd0);

    // Randomized byte stream with random idle gaps.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom_range(1, 255));
      send_frame(rb, 1'b1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    compare_stream("rnd");
    check("rnd_valid_cycles", 32'(valid_cycles), 32'd12);

    // Fill past capacity with the consumer stalled.
    do_reset();
    set_ready(1'b0);
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    check("t4_ovf", {31'd0, overflow}, 32'd1);
    check("t4_head_held", {24'd0, out_data}, 32'h01);
    check("t4_valid", {31'd0, out_valid}, 32'd1);
    set_ready(1'b1);
    repeat (20) @(negedge clk);
    check("t4_empty", {31'd0, out_valid}, 32'd0);
    compare_stream("t4");

    // End-marker handling.
    do_reset();
    set_ready(1'b0);
    send_frame(8'h48, 1'b1);
    check("t5_halt_pre", {31'd0, halt}, 32'd0);
    send_frame(8'h00, 1'b1);
    check("t5_halt_set", {31'd0, halt}, 32'd1);
    send_frame(8'h49, 1'b1);
    set_ready(1'b1);
    repeat (10) @(negedge clk);
    compare_stream("t5");

    // Reset in the middle of a frame.
    do_reset();
    @(negedge clk) rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    do_reset();
    send_frame(8'h7E, 1'b1);
    repeat (4) @(negedge clk);
    compare_stream("t6");
    check("t6_ferr", 32'(fe_cycles), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
